// File: rtl/back_prop_if.sv
// Delta stream from back_prop to the weight/bias update blocks.
interface back_prop_if;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
  logic [6:0]  out_idx;
  logic [15:0] out_data;

  modport master (output out_valid, out_sel, out_idx, out_data, input out_ready);
  modport slave  (input out_valid, out_sel, out_idx, out_data, output out_ready);
endinterface

// File: rtl/back_prop.sv
// Backward pass for the 9-5-4 Q-network: output/hidden error, then a stream of
// all bias and weight deltas over a valid/ready interface, one shared multiplier.
module back_prop #(
  parameter int unsigned LR_SHIFT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [143:0] x,
  input  logic [79:0]  a2,
  input  logic [63:0]  a3,
  input  logic [63:0]  target,
  input  logic [319:0] w3,
  output logic         busy,
  output logic         done,
  back_prop_if.master  stream
);

  typedef enum logic [2:0] {IDLE, ERR, HID, STREAM, DONE} state_e;

  state_e state_q, state_d;

  logic signed [15:0] x_q  [9];
  logic signed [15:0] a2_q [5];
  logic signed [15:0] a3_q [4];
  logic signed [15:0] t_q  [4];
  logic signed [15:0] w3_q [20];
  logic signed [15:0] e_q  [4];
  logic signed [15:0] h_q  [5];

  logic signed [31:0] acc_q, acc_d, mac_sum;
  logic [3:0] oi_q, oi_d;
  logic [2:0] ii_q, ii_d;
  logic [1:0] sel_q, sel_d;
  logic [6:0] idx_q, idx_d;

  logic [4:0] w3_idx;
  logic signed [15:0] mul_a, mul_b, prod, grad, grad_sh, delta;
  logic hs, last_in, last_out;

  function automatic logic signed [15:0] sat32(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [15:0] qmul(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    if (p[31:25] == 7'h00 || p[31:25] == 7'h7F) return p[25:10];
    else return p[31] ? 16'sh8000 : 16'sh7FFF;
  endfunction

  function automatic logic signed [15:0] sub_sat(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic [16:0] s;
    s = {a[15], a} - {b[15], b};
    if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7FFF;
    else return s[15:0];
  endfunction

  // Outer/inner counters walk j,k in HID and the current segment in STREAM.
  always_comb begin
    w3_idx = {oi_q[2:0], 2'b00} + {3'b000, ii_q[1:0]};
    mul_a  = '0;
    mul_b  = '0;
    if (state_q == HID) begin
      mul_a = w3_q[w3_idx];
      mul_b = e_q[ii_q[1:0]];
    end else if (sel_q == 2'd1) begin
      mul_a = a2_q[oi_q[2:0]];
      mul_b = e_q[ii_q[1:0]];
    end else begin
      mul_a = x_q[oi_q];
      mul_b = h_q[ii_q];
    end
    prod    = qmul(mul_a, mul_b);
    mac_sum = ((ii_q == 3'd0) ? 32'sd0 : acc_q) + {{16{prod[15]}}, prod};

    case (sel_q)
      2'd0:    grad = e_q[ii_q[1:0]];
      2'd2:    grad = h_q[ii_q];
      default: grad = prod;
    endcase
    grad_sh = grad >>> LR_SHIFT;
    delta   = (grad_sh == 16'sh8000) ? 16'sh7FFF : -grad_sh;

    last_in = (ii_q == (sel_q[1] ? 3'd4 : 3'd3));
    case (sel_q)
      2'd1:    last_out = (oi_q == 4'd4);
      2'd3:    last_out = (oi_q == 4'd8);
      default: last_out = 1'b1;
    endcase
    hs = (state_q == STREAM) && stream.out_ready;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    oi_d    = oi_q;
    ii_d    = ii_q;
    sel_d   = sel_q;
    idx_d   = idx_q;

    busy            = (state_q != IDLE);
    done            = (state_q == DONE);
    stream.out_valid = (state_q == STREAM);
    stream.out_sel   = sel_q;
    stream.out_idx   = idx_q;
    stream.out_data  = (state_q == STREAM) ? delta : '0;

    case (state_q)
      IDLE: if (start) state_d = ERR;
      ERR:  state_d = HID;
      HID: begin
        acc_d = mac_sum;
        if (last_in) begin
          ii_d = '0;
          if (oi_q == 4'd4) begin
            oi_d    = '0;
            state_d = STREAM;
          end else begin
            oi_d = oi_q + 4'd1;
          end
        end else begin
          ii_d = ii_q + 3'd1;
        end
      end
      STREAM: begin
        if (hs) begin
          idx_d = idx_q + 7'd1;
          if (last_in) begin
            ii_d = '0;
            if (last_out) begin
              oi_d = '0;
              if (sel_q == 2'd3) begin
                sel_d   = '0;
                idx_d   = '0;
                state_d = DONE;
              end else begin
                sel_d = sel_q + 2'd1;
              end
            end else begin
              oi_d = oi_q + 4'd1;
            end
          end else begin
            ii_d = ii_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      oi_q    <= '0;
      ii_q    <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      for (int unsigned i = 0; i < 9; i++)  x_q[i]  <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        a2_q[i] <= '0;
        h_q[i]  <= '0;
      end
      for (int unsigned i = 0; i < 4; i++) begin
        a3_q[i] <= '0;
        t_q[i]  <= '0;
        e_q[i]  <= '0;
      end
      for (int unsigned i = 0; i < 20; i++) w3_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      oi_q    <= oi_d;
      ii_q    <= ii_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      if (state_q == IDLE && start) begin
        for (int unsigned i = 0; i < 9; i++)  x_q[i]  <= x[16*i +: 16];
        for (int unsigned i = 0; i < 5; i++)  a2_q[i] <= a2[16*i +: 16];
        for (int unsigned i = 0; i < 4; i++) begin
          a3_q[i] <= a3[16*i +: 16];
          t_q[i]  <= target[16*i +: 16];
        end
        for (int unsigned i = 0; i < 20; i++) w3_q[i] <= w3[16*i +: 16];
      end
      if (state_q == ERR) begin
        for (int unsigned i = 0; i < 4; i++) e_q[i] <= sub_sat(a3_q[i], t_q[i]);
      end
      // ReLU derivative: hidden error only flows through active units.
      if (state_q == HID && last_in) begin
        h_q[oi_q[2:0]] <= (a2_q[oi_q[2:0]] > 16'sd0) ? sat32(mac_sum) : 16'sd0;
      end
    end
  end

endmodule
